// File: rtl/paula_audio_pkg.sv
// Shared types and helpers for the time-multiplexed Paula audio mixer.
//   mix_mode_e : stereo separation mode applied in the MIX step
//   state_e    : mixer FSM state encoding
//   calc_pw    : width of one signed sample x unsigned volume product
//   calc_aw    : width of the L/R accumulators (product + channel growth + sign)
//   sat_clamp  : clamp a wide signed value into a signed ow-bit range
package paula_audio_pkg;

  typedef enum logic [1:0] {
    MIX_STEREO = 2'd0,
    MIX_XFEED  = 2'd1,
    MIX_MONO   = 2'd2,
    MIX_SWAP   = 2'd3
  } mix_mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_MIX  = 2'd2
  } state_e;

  function automatic int calc_pw(input int sw, input int vw);
    return sw + vw - 1;
  endfunction

  function automatic int calc_aw(input int sw, input int vw, input int nch);
    return calc_pw(sw, vw) + $clog2(nch) + 1;
  endfunction

  // Caller truncates the result to ow bits; the clamped value always fits.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v, input int ow);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/paula_audio_mac_gen.sv
// Per-channel product stage, shared over time by all channels.
//   sample : signed channel sample (SW bits)
//   vol    : Paula volume; MSB forces full scale 2^(VW-1)
//   mute   : 1 forces the product to zero
//   prod   : signed sample x effective volume, SW+VW-1 bits
module paula_audio_mac_gen
  import paula_audio_pkg::*;
#(
  parameter int SW = 8,
  parameter int VW = 7
) (
  input  logic [SW-1:0]           sample,
  input  logic [VW-1:0]           vol,
  input  logic                    mute,
  output logic signed [SW+VW-2:0] prod
);

  localparam int PW = calc_pw(SW, VW);

  logic [VW-1:0]        evol;
  logic signed [PW-1:0] s_ext;
  logic signed [PW-1:0] e_ext;

  assign evol  = vol[VW-1] ? VW'(1 << (VW - 1)) : {1'b0, vol[VW-2:0]};
  // Volume is zero-extended so it stays non-negative in the signed multiply;
  // the exact product always fits PW bits.
  assign s_ext = {{(VW-1){sample[SW-1]}}, sample};
  assign e_ext = {{(SW-1){1'b0}}, evol};
  assign prod  = mute ? '0 : s_ext * e_ext;

endmodule

// File: rtl/paula_audio_mixer_gen.sv
// Time-multiplexed stereo mixer for the Paula audio path.
// A frame starts on clk7_en while idle: inputs are snapshotted, then one
// channel per clock is accumulated into L or R (by ROUTE), then the MIX step
// applies the separation mode, saturates to OW bits and pulses out_valid.
//   clk, reset           : bus clock, asynchronous active-high reset
//   clk7_en              : frame start strobe (ignored while busy)
//   sample/vol/mute/mode : per-channel inputs, channel i at [i*W +: W]
//   ldatasum/rdatasum    : registered saturated outputs, held between frames
//   out_valid            : one-cycle pulse when the outputs update
//   busy                 : high from the first ACC cycle through MIX
// Handshake: out_valid is a pure strobe with no ready; a clk7_en seen while
// busy is dropped, never queued.
module paula_audio_mixer_gen
  import paula_audio_pkg::*;
#(
  parameter int             NCH   = 4,
  parameter int             SW    = 8,
  parameter int             VW    = 7,
  parameter int             OW    = 16,
  parameter logic [NCH-1:0] ROUTE = 4'b0110
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk7_en,
  input  logic [NCH*SW-1:0]     sample,
  input  logic [NCH*VW-1:0]     vol,
  input  logic [NCH-1:0]        mute,
  input  logic [1:0]            mode,
  output logic signed [OW-1:0]  ldatasum,
  output logic signed [OW-1:0]  rdatasum,
  output logic                  out_valid,
  output logic                  busy
);

  localparam int PW = calc_pw(SW, VW);
  localparam int AW = calc_aw(SW, VW, NCH);
  localparam int KW = $clog2(NCH);
  localparam int MW = AW + 1;

  state_e               state;
  logic [KW-1:0]        k;
  logic [NCH*SW-1:0]    samp_q;
  logic [NCH*VW-1:0]    vol_q;
  logic [NCH-1:0]       mute_q;
  mix_mode_e            mode_q;
  logic signed [AW-1:0] acc_l;
  logic signed [AW-1:0] acc_r;

  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] prod_ext;
  logic signed [MW-1:0] l_ext, r_ext, mix_l, mix_r;

  paula_audio_mac_gen #(
    .SW(SW),
    .VW(VW)
  ) u_mac (
    .sample(samp_q[k*SW +: SW]),
    .vol   (vol_q[k*VW +: VW]),
    .mute  (mute_q[k]),
    .prod  (prod)
  );

  assign prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
  assign l_ext    = {acc_l[AW-1], acc_l};
  assign r_ext    = {acc_r[AW-1], acc_r};

  // One extra bit over the accumulators covers L+R and L+(R>>>2).
  always_comb begin
    mix_l = l_ext;
    mix_r = r_ext;
    case (mode_q)
      MIX_XFEED: begin
        mix_l = l_ext + (r_ext >>> 2);
        mix_r = r_ext + (l_ext >>> 2);
      end
      MIX_MONO: begin
        mix_l = l_ext + r_ext;
        mix_r = l_ext + r_ext;
      end
      MIX_SWAP: begin
        mix_l = r_ext;
        mix_r = l_ext;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      k         <= '0;
      samp_q    <= '0;
      vol_q     <= '0;
      mute_q    <= '0;
      mode_q    <= MIX_STEREO;
      acc_l     <= '0;
      acc_r     <= '0;
      ldatasum  <= '0;
      rdatasum  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (clk7_en) begin
            samp_q <= sample;
            vol_q  <= vol;
            mute_q <= mute;
            mode_q <= mix_mode_e'(mode);
            acc_l  <= '0;
            acc_r  <= '0;
            k      <= '0;
            busy   <= 1'b1;
            state  <= S_ACC;
          end
        end
        S_ACC: begin
          if (ROUTE[k]) acc_r <= acc_r + prod_ext;
          else          acc_l <= acc_l + prod_ext;
          if (k == KW'(NCH - 1)) begin
            k     <= '0;
            state <= S_MIX;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_MIX: begin
          ldatasum  <= OW'(sat_clamp(64'(mix_l), OW));
          rdatasum  <= OW'(sat_clamp(64'(mix_r), OW));
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_paula_audio_mixer_gen.sv
// Bench for paula_audio_mixer_gen: two instances share all inputs, one with
// OW=16 and one with OW=15 so saturation is exercised at both widths.
module tb_paula_audio_mixer_gen;

  localparam int NCH = 4;
  localparam int SW  = 8;
  localparam int VW  = 7;
  localparam logic [NCH-1:0] ROUTE = 4'b0110;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              clk7_en = 1'b0;
  logic [NCH*SW-1:0] sample  = '0;
  logic [NCH*VW-1:0] vol     = '0;
  logic [NCH-1:0]    mute    = '0;
  logic [1:0]        mode    = '0;

  logic signed [15:0] l16, r16;
  logic signed [14:0] l15, r15;
  logic ov16, ov15, busy16, busy15;

  logic [NCH-1:0] route_v = ROUTE;
  int total = 0;
  int bad   = 0;

  longint exp_l16, exp_r16, exp_l15, exp_r15;
  logic [31:0] exp_q[$];

  paula_audio_mixer_gen #(.NCH(NCH), .SW(SW), .VW(VW), .OW(16), .ROUTE(ROUTE)) dut (
    .clk(clk), .reset(reset), .clk7_en(clk7_en), .sample(sample), .vol(vol),
    .mute(mute), .mode(mode), .ldatasum(l16), .rdatasum(r16),
    .out_valid(ov16), .busy(busy16)
  );

  paula_audio_mixer_gen #(.NCH(NCH), .SW(SW), .VW(VW), .OW(15), .ROUTE(ROUTE)) dut15 (
    .clk(clk), .reset(reset), .clk7_en(clk7_en), .sample(sample), .vol(vol),
    .mute(mute), .mode(mode), .ldatasum(l15), .rdatasum(r15),
    .out_valid(ov15), .busy(busy15)
  );

  // ---------------- reference model ----------------
  function automatic void model(input int ow, output longint lo, output longint ro);
    longint acc_l, acc_r, s, ev, ml, mr, lim;
    acc_l = 0;
    acc_r = 0;
    for (int i = 0; i < NCH; i++) begin
      s  = longint'($signed(sample[i*SW +: SW]));
      ev = vol[i*VW + VW - 1] ? (64'sd1 << (VW - 1)) : longint'(vol[i*VW +: VW]);
      if (!mute[i]) begin
        if (route_v[i]) acc_r += s * ev;
        else            acc_l += s * ev;
      end
    end
    case (mode)
      2'd1: begin ml = acc_l + (acc_r >>> 2); mr = acc_r + (acc_l >>> 2); end
      2'd2: begin ml = acc_l + acc_r;         mr = acc_l + acc_r;         end
      2'd3: begin ml = acc_r;                 mr = acc_l;                 end
      default: begin ml = acc_l;              mr = acc_r;                 end
    endcase
    lim = 64'sd1 << (ow - 1);
    lo = (ml > lim - 1) ? lim - 1 : ((ml < -lim) ? -lim : ml);
    ro = (mr > lim - 1) ? lim - 1 : ((mr < -lim) ? -lim : mr);
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_expect();
    model(16, exp_l16, exp_r16);
    model(15, exp_l15, exp_r15);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".l16"}, l16, exp_l16);
    check({tag, ".r16"}, r16, exp_r16);
    check({tag, ".l15"}, l15, exp_l15);
    check({tag, ".r15"}, r15, exp_r15);
  endtask

  // Leaves the bench in cycle 1 of the frame.
  task automatic pulse();
    clk7_en = 1'b1;
    tick();
    clk7_en = 1'b0;
  endtask

  // cyc_now is the frame cycle the bench currently sits in.
  task automatic wait_valid(input string tag, input int cyc_now);
    int cyc;
    cyc = cyc_now;
    while (ov16 !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    check({tag, ".latency"}, cyc, NCH + 2);
    check({tag, ".valid15"}, ov15, 1);
    check({tag, ".busy_at_valid"}, busy16, 0);
  endtask

  task automatic run_frame(input string tag);
    set_expect();
    pulse();
    wait_valid(tag, 1);
    check_outputs(tag);
    tick();
    check({tag, ".valid_drop"}, ov16, 0);
    check({tag, ".hold_l16"}, l16, exp_l16);
  endtask

  // Drives clk7_en from pat for ncyc cycles with fixed inputs; tracks
  // frame acceptance from the busy window rule and scoreboards each result.
  task automatic run_schedule(input string tag, input logic [63:0] pat, input int ncyc, input int exp_frames);
    int last;
    int pulses;
    logic [31:0] got;
    last   = -100;
    pulses = 0;
    set_expect();
    exp_q.delete();
    for (int c = 0; c < ncyc; c++) begin
      clk7_en = pat[c];
      if (pat[c] && c > last + NCH + 1) begin
        last = c;
        exp_q.push_back({16'(exp_l16), 16'(exp_r16)});
      end
      tick();
      check({tag, ".busy"}, busy16, (c + 1 >= last + 1 && c + 1 <= last + NCH + 1) ? 1 : 0);
      check({tag, ".valid"}, ov16, (c + 1 == last + NCH + 2) ? 1 : 0);
      if (ov16 === 1'b1) begin
        pulses++;
        check({tag, ".queue_nonempty"}, (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          got = exp_q.pop_front();
          check({tag, ".pair"}, {l16, r16}, got);
        end
      end
    end
    clk7_en = 1'b0;
    check({tag, ".frames"}, pulses, exp_frames);
  endtask

  // ---------------- directed sequence ----------------
  int tp_l[4] = '{4096, 3840, 3072, -1024};
  int tp_r[4] = '{-1024, 0, 3072, 4096};
  logic [63:0] pat;

  initial begin
    // Reset state
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst.l16", l16, 0);
    check("rst.r16", r16, 0);
    check("rst.valid", ov16, 0);
    check("rst.busy", busy16, 0);

    // Directed frames over all four modes
    for (int m = 0; m < 4; m++) begin
      sample = {8'h5A, 8'hA5, 8'hE0, 8'h40};
      vol    = {7'h00, 7'h00, 7'h20, 7'h41};
      mute   = '0;
      mode   = 2'(m);
      run_frame($sformatf("tp_mode%0d", m));
      check($sformatf("tp_mode%0d.const_l", m), l16, tp_l[m]);
      check($sformatf("tp_mode%0d.const_r", m), r16, tp_r[m]);
    end

    // Mute of the only active left contributor
    mode = 2'd0;
    mute = 4'b0001;
    run_frame("mute_ch0");
    check("mute_ch0.const_l", l16, 0);

    // Saturation at both widths
    mute   = '0;
    mode   = 2'd2;
    sample = {4{8'h80}};
    vol    = {4{7'h7F}};
    run_frame("sat_neg");
    check("sat_neg.const_l15", l15, -16384);
    check("sat_neg.const_r15", r15, -16384);
    sample = {4{8'h7F}};
    run_frame("sat_pos");
    check("sat_pos.const_l15", l15, 16383);
    check("sat_pos.const_r15", r15, 16383);

    // Random frames
    for (int n = 0; n < 8; n++) begin
      sample = $urandom;
      vol    = 28'($urandom);
      mute   = 4'($urandom);
      mode   = 2'($urandom_range(0, 3));
      run_frame($sformatf("rand%0d", n));
    end

    // Snapshot: inputs changed in cycle 2 only affect the next frame
    sample = $urandom;
    vol    = 28'($urandom);
    mute   = 4'b0000;
    mode   = 2'($urandom_range(0, 3));
    set_expect();
    pulse();
    tick();
    mute   = ~mute;
    sample = $urandom;
    wait_valid("snap_a", 2);
    check_outputs("snap_a");
    tick();
    run_frame("snap_b");

    // clk7_en every 4 clocks, 10 pulses -> 5 frames
    pat = '0;
    for (int c = 0; c < 40; c += 4) pat[c] = 1'b1;
    sample = $urandom;
    vol    = 28'($urandom);
    mute   = 4'($urandom);
    mode   = 2'($urandom_range(0, 3));
    run_schedule("every4", pat, 48, 5);

    // clk7_en during MIX is dropped, the one just after starts a frame
    pat = '0;
    pat[0] = 1'b1;
    pat[5] = 1'b1;
    pat[6] = 1'b1;
    run_schedule("mix_edge", pat, 16, 2);

    // Reset in cycle 3 of a frame
    sample = $urandom;
    vol    = 28'($urandom);
    pulse();
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("midrst.l16", l16, 0);
    check("midrst.r16", r16, 0);
    check("midrst.l15", l15, 0);
    check("midrst.busy", busy16, 0);
    check("midrst.valid", ov16, 0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < NCH + 3; c++) begin
      tick();
      check("midrst.no_valid", ov16, 0);
    end
    run_frame("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/paula_audio_mixer_gen.md
# paula_audio_mixer_gen

Parametrised stereo mixer for the Paula audio path. It replaces the fixed 4-channel combinational mixer with a time-multiplexed multiply-accumulate engine. The engine takes NCH signed samples with Paula-style volumes, a per-channel mute and a configurable left/right routing mask. It applies a selectable stereo-separation mode and a saturating output stage, and produces one left/right pair plus a valid strobe per frame. It sits between the Paula audio channel DMA/state machines and the audio output filter/DAC interface.

## Interface
- NCH, 4: number of channels; even, 2..8.
- SW, 8: sample width, signed two's complement.
- VW, 7: volume width; MSB forces maximum volume.
- OW, 16: output width, signed.
- ROUTE, 4'b0110: bit i = 1 routes channel i right, 0 routes it left.
- clk  in  1  bus clock (28 MHz).
- reset  in  1  asynchronous, active-high.
- clk7_en  in  1  frame start strobe, one clk wide.
- sample  in  NCH*SW  channel i at [i*SW +: SW].
- vol  in  NCH*VW  channel i at [i*VW +: VW].
- mute  in  NCH  1 = channel contributes 0.
- mode  in  2  0 stereo, 1 crossfeed, 2 mono, 3 swap.
- ldatasum  out  OW  left output, registered.
- rdatasum  out  OW  right output, registered.
- out_valid  out  1  one-cycle pulse when ldatasum/rdatasum update.
- busy  out  1  high while a frame is in progress.

## Operation
- Effective volume: evol = vol[VW-1] ? 2^(VW-1) : {1'b0, vol[VW-2:0]}. Range 0..64 at defaults.
- Product: sample (signed) × evol (unsigned), width PW = SW+VW-1. At defaults, -128×64 = -8192 fits 14 bits.
- Muted channel product is forced to 0.
- Accumulators L and R are signed, width AW = PW + clog2(NCH) + 1.
- FSM states:
  - IDLE: on clk7_en, snapshot sample, vol, mute and mode; clear L and R; set k=0; go to ACC.
  - ACC: add channel k's product to R if ROUTE[k], else to L; k++. After k = NCH-1, go to MIX.
  - MIX: compute L', R' (below); saturate to OW; register outputs; pulse out_valid; go to IDLE.
- Mix modes:
  - 0: L'=L, R'=R.
  - 1: L'=L+(R>>>2), R'=R+(L>>>2), arithmetic shift.
  - 2: L'=R'=L+R.
  - 3: L'=R, R'=L.
- Saturation clamps to [-2^(OW-1), 2^(OW-1)-1].
- clk7_en while busy is ignored. No queueing, no partial restart.
- Inputs are snapshotted. Changes during a frame affect only the next frame.
- Reset, including mid-frame: state IDLE, k=0, L=R=0, ldatasum=rdatasum=0, out_valid=0, busy=0. Snapshot registers cleared.

## Timing
- Cycle 0: clk7_en sampled in IDLE; snapshot taken.
- Cycles 1..NCH: ACC, one channel per cycle, in order 0..NCH-1.
- Cycle NCH+1: MIX.
- ldatasum, rdatasum and out_valid change at the end of cycle NCH+1, so they are visible from cycle NCH+2.
- Latency from clk7_en to out_valid is NCH+2 clocks.
- busy is high from cycle 1 through cycle NCH+1 inclusive.
- Outputs hold their value between out_valid pulses.
- With NCH=4 and clk7_en every 4 clk, every second clk7_en starts a frame.
- A clk7_en in the same cycle as MIX is ignored. A clk7_en in the cycle after MIX starts a new frame.

## Structure
- Package paula_audio_pkg holds:
  - the mode enum (MIX_STEREO, MIX_XFEED, MIX_MONO, MIX_SWAP);
  - the FSM state enum (S_IDLE, S_ACC, S_MIX);
  - width helper functions for PW and AW.
- One sub-module, paula_audio_mac_gen: combinational evol decode, mute, and signed×unsigned multiply for the currently selected channel. It is instantiated once and shared over time across all channels.
- Saturation is a package function, not a separate module.

## Test plan
- Defaults, mode 0. ch0 sample 8'h40, vol 7'h41; ch1 sample 8'hE0, vol 7'h20; ch2 and ch3 vol 0. Pulse clk7_en → out_valid exactly 6 clk later; ldatasum=4096, rdatasum=-1024.
- Same stimulus, modes 1/2/3 → (L,R) = (3840,0) / (3072,3072) / (-1024,4096).
- All four channels: sample 8'h80, vol 7'h7F, mode 2, OW=15 → both outputs saturate to -16384. With sample 8'h7F → both saturate to 16383.
- Mute and snapshot:
  - mute=4'b0001 → ldatasum=0 with ch0 as the only left contributor.
  - Toggle mute and sample at cycle 2 of a frame → that frame unchanged, the next frame reflects the change.
- clk7_en every 4 clk for 10 pulses → exactly 5 out_valid pulses; busy never drops mid-frame.
- Assert reset at cycle 3 of a frame → outputs 0, busy=0, no out_valid. After release, a clk7_en yields a correct frame 6 clk later.
